// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin bus arbiter; optional transfer timeout via BUS_ARBITER_TIMEOUT_EN
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [2:0]  m0_option,
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_write_data,
  output logic [31:0] m0_read_data,
  output logic        m0_response,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [2:0]  m1_option,
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_write_data,
  output logic [31:0] m1_read_data,
  output logic        m1_response,
  output logic        s_read,
  output logic        s_write,
  output logic [2:0]  s_option,
  output logic [31:0] s_address,
  output logic [31:0] s_write_data,
  input  logic [31:0] s_read_data,
  input  logic        s_response,
  output logic [1:0]  grant,
  output logic        timeout_error
);

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;  // 1: master 1 was served last, so master 0 wins a tie
  logic   req0, req1;
  logic   timeout_hit;

  assign req0  = m0_read | m0_write;
  assign req1  = m1_read | m1_write;
  assign grant = state_q;

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tcount_q, tcount_d;
  logic          timeout_error_q, timeout_error_d;

  assign timeout_hit   = (state_q != IDLE) && (tcount_q == CW'(TIMEOUT_CYCLES));
  assign timeout_error = timeout_error_q | timeout_hit;

  // Count granted cycles that end without leaving the grant; sticky error flag.
  always_comb begin
    tcount_d        = '0;
    timeout_error_d = timeout_error_q | timeout_hit;
    if ((state_q != IDLE) && (state_d == state_q)) begin
      tcount_d = tcount_q + 1'b1;
    end
  end

  // Timeout counter and error flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcount_q        <= '0;
      timeout_error_q <= 1'b0;
    end else begin
      tcount_q        <= tcount_d;
      timeout_error_q <= timeout_error_d;
    end
  end
`else
  // The timeout limit is only consumed when the timeout feature is built in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout_hit        = 1'b0;
  assign timeout_error      = 1'b0;
`endif

  // Arbitration, completion and abort decisions.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          state_d = last_q ? GRANT0 : GRANT1;
        end else if (req0) begin
          state_d = GRANT0;
        end else if (req1) begin
          state_d = GRANT1;
        end
      end
      GRANT0: begin
        if (timeout_hit || s_response) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end else if (!req0) begin
          state_d = IDLE;
        end
      end
      GRANT1: begin
        if (timeout_hit || s_response) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end else if (!req1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and last-served pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Combinational routing between the owning master and the slave side.
  always_comb begin
    s_read       = 1'b0;
    s_write      = 1'b0;
    s_option     = 3'd0;
    s_address    = 32'd0;
    s_write_data = 32'd0;
    m0_read_data = 32'd0;
    m0_response  = 1'b0;
    m1_read_data = 32'd0;
    m1_response  = 1'b0;
    case (state_q)
      GRANT0: begin
        s_read       = m0_read;
        s_write      = m0_write;
        s_option     = m0_option;
        s_address    = m0_address;
        s_write_data = m0_write_data;
        m0_read_data = s_read_data;
        m0_response  = s_response;
      end
      GRANT1: begin
        s_read       = m1_read;
        s_write      = m1_write;
        s_option     = m1_option;
        s_address    = m1_address;
        s_write_data = m1_write_data;
        m1_read_data = s_read_data;
        m1_response  = s_response;
      end
      default: ;
    endcase
    if (timeout_hit) begin
      s_read  = 1'b0;
      s_write = 1'b0;
      if (state_q == GRANT0) begin
        m0_response  = 1'b1;
        m0_read_data = 32'hDEADBEEF;
      end else begin
        m1_response  = 1'b1;
        m1_read_data = 32'hDEADBEEF;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed and randomized checks of bus_arbiter against a transaction-level model
module tb_bus_arbiter;

  localparam int TO = 8;
`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m_rd [2];
  logic        m_wr [2];
  logic [2:0]  m_opt [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wdata [2];
  logic [31:0] s_rdata;
  logic        s_resp;

  logic [31:0] m0_read_data, m1_read_data;
  logic        m0_response, m1_response;
  logic        s_read, s_write;
  logic [2:0]  s_option;
  logic [31:0] s_address, s_write_data;
  logic [1:0]  grant;
  logic        timeout_error;

  logic [31:0] got_rdata [2];
  logic        got_rsp [2];
  assign got_rdata[0] = m0_read_data;
  assign got_rdata[1] = m1_read_data;
  assign got_rsp[0]   = m0_response;
  assign got_rsp[1]   = m1_response;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the bus, who was served last, how long the owner has held it.
  int owner = -1;
  int last  = 1;
  int gcnt  = 0;
  bit terr  = 1'b0;

  bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_read(m_rd[0]), .m0_write(m_wr[0]), .m0_option(m_opt[0]),
    .m0_address(m_addr[0]), .m0_write_data(m_wdata[0]),
    .m0_read_data(m0_read_data), .m0_response(m0_response),
    .m1_read(m_rd[1]), .m1_write(m_wr[1]), .m1_option(m_opt[1]),
    .m1_address(m_addr[1]), .m1_write_data(m_wdata[1]),
    .m1_read_data(m1_read_data), .m1_response(m1_response),
    .s_read(s_read), .s_write(s_write), .s_option(s_option),
    .s_address(s_address), .s_write_data(s_write_data),
    .s_read_data(s_rdata), .s_response(s_resp),
    .grant(grant), .timeout_error(timeout_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      m_rd[i] = 1'b0; m_wr[i] = 1'b0; m_opt[i] = 3'd0;
      m_addr[i] = 32'd0; m_wdata[i] = 32'd0;
    end
    s_resp  = 1'b0;
    s_rdata = 32'd0;
  endtask

  task automatic model_check();
    int          own;
    bit          tout;
    logic [1:0]  eg;
    logic        e_rd, e_wr;
    logic [2:0]  e_opt;
    logic [31:0] e_addr, e_wd;
    own  = reset ? owner : -1;
    tout = TO_EN && (own >= 0) && (gcnt == TO);
    eg = 2'b00; e_rd = 1'b0; e_wr = 1'b0; e_opt = 3'd0; e_addr = 32'd0; e_wd = 32'd0;
    if (own >= 0) begin
      eg     = (own == 0) ? 2'b01 : 2'b10;
      e_rd   = tout ? 1'b0 : m_rd[own];
      e_wr   = tout ? 1'b0 : m_wr[own];
      e_opt  = m_opt[own];
      e_addr = m_addr[own];
      e_wd   = m_wdata[own];
    end
    chk("grant", grant, eg);
    chk("s_read", s_read, e_rd);
    chk("s_write", s_write, e_wr);
    chk("s_option", s_option, e_opt);
    chk("s_address", s_address, e_addr);
    chk("s_write_data", s_write_data, e_wd);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("m%0d_response", i), got_rsp[i],
          (own == i) ? (tout ? 1'b1 : s_resp) : 1'b0);
      chk($sformatf("m%0d_read_data", i), got_rdata[i],
          (own == i) ? (tout ? 32'hDEADBEEF : s_rdata) : 32'd0);
    end
    chk("timeout_error", timeout_error, reset && (terr || tout));
  endtask

  task automatic model_update();
    bit r0, r1, tout;
    r0 = m_rd[0] | m_wr[0];
    r1 = m_rd[1] | m_wr[1];
    if (!reset) begin
      owner = -1; last = 1; gcnt = 0; terr = 1'b0;
    end else if (owner < 0) begin
      gcnt = 0;
      if (r0 && r1) owner = 1 - last;
      else if (r0)  owner = 0;
      else if (r1)  owner = 1;
    end else begin
      tout = TO_EN && (gcnt == TO);
      if (tout || s_resp) begin
        if (tout) terr = 1'b1;
        last = owner; owner = -1; gcnt = 0;
      end else if (!(m_rd[owner] | m_wr[owner])) begin
        owner = -1; gcnt = 0;
      end else begin
        gcnt++;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    sample();
    chk("rst_grant", grant, 2'b00);
    advance();
    clear_inputs();
    reset = 1'b1;
  endtask

  initial begin
    clear_inputs();
    m_rd[0] = 1'b1; m_rd[1] = 1'b1; m_addr[0] = 32'h10; m_addr[1] = 32'h20;
    s_resp = 1'b1; s_rdata = 32'hA5A5A5A5;
    reset = 1'b0;
    sample();
    chk("rst_s_read", s_read, 1'b0);
    chk("rst_s_address", s_address, 32'd0);
    chk("rst_m0_rsp", m0_response, 1'b0);
    chk("rst_m1_data", m1_read_data, 32'd0);
    chk("rst_terr", timeout_error, 1'b0);
    advance();
    advance();
    clear_inputs();
    reset = 1'b1;

    // Single master 0 read with a one-cycle slave delay.
    m_rd[0] = 1'b1; m_addr[0] = 32'h0000_0010; m_opt[0] = 3'd2;
    sample(); chk("r30_grant_idle", grant, 2'b00); advance();
    sample(); chk("r30_grant01", grant, 2'b01); chk("r30_s_read", s_read, 1'b1);
    chk("r30_s_addr", s_address, 32'h10); chk("r30_no_rsp", m0_response, 1'b0); advance();
    s_resp = 1'b1; s_rdata = 32'h12345678;
    sample(); chk("r30_m0_rsp", m0_response, 1'b1); chk("r30_m0_data", m0_read_data, 32'h12345678);
    chk("r30_m1_rsp", m1_response, 1'b0); advance();
    m_rd[0] = 1'b0; s_resp = 1'b0; s_rdata = 32'd0;
    sample(); chk("r30_grant00", grant, 2'b00); advance();

    // Simultaneous requests right after reset: 01,00,10,00.
    do_reset();
    m_rd[0] = 1'b1; m_rd[1] = 1'b1; m_addr[0] = 32'h100; m_addr[1] = 32'h200;
    sample(); chk("r31_idle", grant, 2'b00); advance();
    s_resp = 1'b1;
    sample(); chk("r31_g01", grant, 2'b01); chk("r31_m0_rsp", m0_response, 1'b1);
    chk("r31_m1_rsp0", m1_response, 1'b0); advance();
    m_rd[0] = 1'b0; s_resp = 1'b0;
    sample(); chk("r31_g00a", grant, 2'b00); advance();
    s_resp = 1'b1;
    sample(); chk("r31_g10", grant, 2'b10); chk("r31_m1_rsp", m1_response, 1'b1);
    chk("r31_m0_rsp0", m0_response, 1'b0); advance();
    m_rd[1] = 1'b0; s_resp = 1'b0;
    sample(); chk("r31_g00b", grant, 2'b00); advance();

    // Master 1 holds while master 0 writes back-to-back: grants alternate.
    do_reset();
    m_wr[0] = 1'b1; m_wdata[0] = 32'hBEEF0000; m_rd[1] = 1'b1; m_addr[1] = 32'h300;
    s_resp = 1'b1;
    for (int k = 0; k < 13; k++) begin
      sample();
      chk($sformatf("r32_grant_k%0d", k), grant,
          (k % 2 == 0) ? 2'b00 : (((k / 2) % 2 == 0) ? 2'b01 : 2'b10));
      advance();
    end
    clear_inputs();

    // Abort: master 0 drops its read after two granted cycles; pointer unchanged.
    do_reset();
    m_rd[0] = 1'b1; m_addr[0] = 32'h400;
    sample(); advance();
    sample(); chk("r33_g1", grant, 2'b01); advance();
    sample(); chk("r33_g2", grant, 2'b01); advance();
    m_rd[0] = 1'b0;
    sample(); chk("r33_s_read", s_read, 1'b0); chk("r33_no_rsp", m0_response, 1'b0); advance();
    m_rd[0] = 1'b1; m_rd[1] = 1'b1;
    sample(); chk("r33_idle", grant, 2'b00); chk("r33_no_rsp2", m0_response, 1'b0); advance();
    sample(); chk("r33_ptr", grant, 2'b01); advance();
    clear_inputs();

    // Asynchronous reset in the middle of a master 1 grant.
    do_reset();
    m_rd[1] = 1'b1; m_addr[1] = 32'h2000;
    sample(); advance();
    sample(); chk("r34_pre", grant, 2'b10);
    s_resp = 1'b1; s_rdata = 32'hCAFEF00D;
    reset = 1'b0;
    #1;
    chk("r34_grant", grant, 2'b00);
    chk("r34_s_read", s_read, 1'b0);
    chk("r34_s_addr", s_address, 32'd0);
    chk("r34_m1_rsp", m1_response, 1'b0);
    chk("r34_m1_data", m1_read_data, 32'd0);
    advance();
    clear_inputs();
    reset = 1'b1;

`ifdef BUS_ARBITER_TIMEOUT_EN
    // Silent slave: forced error response after TO granted cycles.
    do_reset();
    m_rd[0] = 1'b1; m_addr[0] = 32'h40;
    sample(); advance();
    for (int k = 0; k < TO; k++) begin
      sample(); chk("to_wait_rsp", m0_response, 1'b0); chk("to_wait_err", timeout_error, 1'b0); advance();
    end
    sample(); chk("to_rsp", m0_response, 1'b1); chk("to_data", m0_read_data, 32'hDEADBEEF);
    chk("to_s_read", s_read, 1'b0); chk("to_err", timeout_error, 1'b1); advance();
    m_rd[0] = 1'b0;
    sample(); chk("to_idle", grant, 2'b00); chk("to_err_held", timeout_error, 1'b1); advance();
    sample(); chk("to_err_held2", timeout_error, 1'b1); advance();
`else
    // Silent slave without the timeout feature: the grant is held indefinitely.
    do_reset();
    m_rd[0] = 1'b1; m_addr[0] = 32'h40;
    sample(); advance();
    for (int k = 0; k < 3 * TO; k++) begin
      sample(); advance();
    end
    sample(); chk("nto_grant", grant, 2'b01); chk("nto_rsp", m0_response, 1'b0);
    chk("nto_err", timeout_error, 1'b0); advance();
`endif
    clear_inputs();

    // Randomized traffic with occasional aborts, dual strobes and resets.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (m_rd[i] | m_wr[i]) begin
          if ($urandom_range(0, 9) == 0) begin
            m_rd[i] = 1'b0; m_wr[i] = 1'b0;
          end
        end else if ($urandom_range(0, 9) < 4) begin
          case ($urandom_range(0, 4))
            0, 1:    begin m_rd[i] = 1'b1; m_wr[i] = 1'b0; end
            2, 3:    begin m_rd[i] = 1'b0; m_wr[i] = 1'b1; end
            default: begin m_rd[i] = 1'b1; m_wr[i] = 1'b1; end
          endcase
          m_opt[i]   = 3'($urandom_range(0, 7));
          m_addr[i]  = $urandom;
          m_wdata[i] = $urandom;
        end
      end
      s_resp  = ($urandom_range(0, 9) < 3);
      s_rdata = $urandom;
      reset   = ($urandom_range(0, 299) != 0);
      sample();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
